// File: rtl/uart_fifo_ctrl_if.sv
// Bundle of the write/read handshakes, RAM port, fill level and statistics
// signals that pass between uart_fifo_ctrl and its surroundings.
interface uart_fifo_ctrl_if #(
    parameter int Width = 8,
    parameter int Depth = 16
);
    localparam int AW = $clog2(Depth);

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [Width-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [Width-1:0] out_data;
    logic [AW:0]      level;
    logic             mem_wr_enable;
    logic [AW-1:0]    mem_wr_address;
    logic [Width-1:0] mem_wr_data;
    logic [AW-1:0]    mem_rd_address;
    logic [Width-1:0] mem_rd_data;
    logic             overflow;
    logic [AW:0]      peak_level;

    modport master (
        output flush, in_valid, in_data, out_ready, mem_rd_data,
        input  in_ready, out_valid, out_data, level, mem_wr_enable,
               mem_wr_address, mem_wr_data, mem_rd_address, overflow, peak_level
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready, mem_rd_data,
        output in_ready, out_valid, out_data, level, mem_wr_enable,
               mem_wr_address, mem_wr_data, mem_rd_address, overflow, peak_level
    );
endinterface

// File: rtl/uart_fifo_ctrl.sv
// FIFO controller around an external RAM with 1-cycle synchronous read.
// Define UART_FIFO_CTRL_STATS_EN to build the sticky overflow / peak_level statistics.
module uart_fifo_ctrl #(
    parameter int Width = 8,
    parameter int Depth = 16
) (
    input logic           clk,
    input logic           rst,
    uart_fifo_ctrl_if.slave bus
);
    localparam int AW = $clog2(Depth);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(Depth);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level;
    logic [LW-1:0]    level_next;
    logic [LW-1:0]    vcount;
    logic             push_q;
    logic             in_ready_c;
    logic             out_valid_c;
    logic             push;
    logic             pop;
    logic [Width-1:0] rd_word;

    always_comb begin
        in_ready_c  = !rst && !bus.flush && (level < FULL);
        out_valid_c = !rst && !bus.flush && (vcount != '0);
        push        = bus.in_valid && in_ready_c;
        pop         = out_valid_c && bus.out_ready;
    end

    always_comb begin
        level_next = level;
        if (bus.flush) begin
            level_next = '0;
        end else if (push && !pop) begin
            level_next = level + LW'(1);
        end else if (pop && !push) begin
            level_next = level - LW'(1);
        end
    end

    // Look one entry ahead when popping so the next word lands in time.
    assign bus.mem_rd_address = pop ? rd_ptr + AW'(1) : rd_ptr;
    assign rd_word            = bus.mem_rd_data;

    assign bus.in_ready       = in_ready_c;
    assign bus.out_valid      = out_valid_c;
    assign bus.out_data       = rd_word;
    assign bus.level          = level;
    assign bus.mem_wr_enable  = push;
    assign bus.mem_wr_address = wr_ptr;
    assign bus.mem_wr_data    = bus.in_data;

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            vcount <= '0;
            push_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            level  <= level_next;
            // A word becomes visible only once the RAM read pipeline has caught up.
            vcount <= vcount + LW'(push_q) - LW'(pop);
            push_q <= push;
        end
    end

`ifdef UART_FIFO_CTRL_STATS_EN
    logic          overflow_q;
    logic [LW-1:0] peak_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
            peak_q     <= '0;
        end else begin
            if (bus.in_valid && !in_ready_c && (level == FULL)) overflow_q <= 1'b1;
            if (level_next > peak_q) peak_q <= level_next;
        end
    end

    assign bus.overflow   = overflow_q;
    assign bus.peak_level = peak_q;
`else
    assign bus.overflow   = 1'b0;
    assign bus.peak_level = '0;
`endif

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Self-checking bench for uart_fifo_ctrl: directed scenarios plus a randomized run,
// all checked against a queue-based reference model and a behavioural sync-read RAM.
module tb_uart_fifo_ctrl;
    localparam int W  = 8;
    localparam int D  = 16;
    localparam int LW = $clog2(D) + 1;
`ifdef UART_FIFO_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_fifo_ctrl_if #(.Width(W), .Depth(D)) bus ();
    uart_fifo_ctrl #(.Width(W), .Depth(D)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [W-1:0] ram [D];
    always @(posedge clk) begin
        if (bus.mem_wr_enable) ram[bus.mem_wr_address] <= bus.mem_wr_data;
        bus.mem_rd_data <= ram[bus.mem_rd_address];
    end

    typedef struct {
        logic [W-1:0] data;
        int           cyc;
    } entry_t;

    entry_t       q[$];
    int           cyc = 0;
    int           wr_count = 0;
    logic         exp_in_ready, exp_out_valid, exp_push, exp_pop, exp_ovf_set;
    logic [W-1:0] exp_out_data;
    logic         exp_ovf = 1'b0;
    int           exp_peak = 0;
    int           tests_run = 0;
    int           tests_failed = 0;

    task automatic drive(input logic v, input logic [W-1:0] d, input logic r,
                         input logic f, input logic rs);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        bus.flush     = f;
        rst           = rs;
        #1;
        exp_in_ready  = !rs && !f && (q.size() < D);
        exp_out_valid = 1'b0;
        exp_out_data  = '0;
        if (q.size() > 0) begin
            exp_out_valid = !rs && !f && (q[0].cyc <= cyc - 2);
            exp_out_data  = q[0].data;
        end
        exp_push    = v && exp_in_ready;
        exp_pop     = exp_out_valid && r;
        exp_ovf_set = v && !exp_in_ready && (q.size() == D);
    endtask

    task automatic advance();
        entry_t e;
        @(posedge clk);
        if (rst) begin
            q.delete();
            wr_count = 0;
            exp_ovf  = 1'b0;
            exp_peak = 0;
        end else begin
            if (bus.flush) begin
                q.delete();
                wr_count = 0;
            end else begin
                if (exp_pop) void'(q.pop_front());
                if (exp_push) begin
                    e.data = bus.in_data;
                    e.cyc  = cyc;
                    q.push_back(e);
                    wr_count++;
                end
            end
            if (STATS && exp_ovf_set) exp_ovf = 1'b1;
            if (STATS && q.size() > exp_peak) exp_peak = q.size();
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b1, 8'h11, 1'b1, 1'b0, 1'b1);
        tests_run++; if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
        tests_run++; if (bus.mem_wr_enable !== 1'b0) begin tests_failed++; $display("FAIL rst_wr_en: got %b want 0", bus.mem_wr_enable); end
        advance();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        advance();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tests_run++; if (bus.level !== LW'(0)) begin tests_failed++; $display("FAIL rst_level: got %0d want 0", bus.level); end
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_out_valid_after: got %b want 0", bus.out_valid); end
        tests_run++; if (bus.mem_rd_address !== 4'd0) begin tests_failed++; $display("FAIL rst_rd_addr: got %0d want 0", bus.mem_rd_address); end
        tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_in_ready_after: got %b want 1", bus.in_ready); end
        tests_run++; if (bus.overflow !== 1'b0) begin tests_failed++; $display("FAIL rst_overflow: got %b want 0", bus.overflow); end
        tests_run++; if (bus.peak_level !== LW'(0)) begin tests_failed++; $display("FAIL rst_peak: got %0d want 0", bus.peak_level); end
    endtask

    task automatic test_first_word();
        drive(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        tests_run++; if (bus.mem_wr_enable !== 1'b1 || bus.mem_wr_data !== 8'hA5) begin tests_failed++; $display("FAIL first_write: got en=%b data=%h want en=1 data=a5", bus.mem_wr_enable, bus.mem_wr_data); end
        advance();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tests_run++; if (bus.level !== LW'(1)) begin tests_failed++; $display("FAIL first_level: got %0d want 1", bus.level); end
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL first_early_valid: got %b want 0", bus.out_valid); end
        advance();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tests_run++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5) begin tests_failed++; $display("FAIL first_out: got valid=%b data=%h want valid=1 data=a5", bus.out_valid, bus.out_data); end
        advance();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tests_run++; if (bus.level !== LW'(0)) begin tests_failed++; $display("FAIL first_drained: got %0d want 0", bus.level); end
    endtask

    task automatic test_full();
        for (int i = 0; i < D; i++) begin
            drive(1'b1, W'(i), 1'b0, 1'b0, 1'b0);
            tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL fill_ready[%0d]: got %b want 1", i, bus.in_ready); end
            advance();
        end
        drive(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        tests_run++; if (bus.level !== LW'(D)) begin tests_failed++; $display("FAIL full_level: got %0d want %0d", bus.level, D); end
        tests_run++; if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL full_in_ready: got %b want 0", bus.in_ready); end
        tests_run++; if (bus.mem_wr_enable !== 1'b0) begin tests_failed++; $display("FAIL full_wr_en: got %b want 0", bus.mem_wr_enable); end
        advance();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tests_run++; if (bus.level !== LW'(D)) begin tests_failed++; $display("FAIL full_level_hold: got %0d want %0d", bus.level, D); end
        tests_run++; if (bus.overflow !== STATS) begin tests_failed++; $display("FAIL full_overflow: got %b want %b", bus.overflow, STATS); end
        tests_run++; if (bus.peak_level !== (STATS ? LW'(D) : LW'(0))) begin tests_failed++; $display("FAIL full_peak: got %0d want %0d", bus.peak_level, STATS ? D : 0); end
    endtask

    task automatic test_full_pop();
        drive(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        tests_run++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h00) begin tests_failed++; $display("FAIL fullpop_out: got valid=%b data=%h want valid=1 data=00", bus.out_valid, bus.out_data); end
        tests_run++; if (bus.in_ready !== 1'b0 || bus.mem_wr_enable !== 1'b0) begin tests_failed++; $display("FAIL fullpop_push_blocked: got ready=%b en=%b want 0 0", bus.in_ready, bus.mem_wr_enable); end
        advance();
        drive(1'b1, 8'h78, 1'b0, 1'b0, 1'b0);
        tests_run++; if (bus.level !== LW'(D - 1)) begin tests_failed++; $display("FAIL fullpop_level: got %0d want %0d", bus.level, D - 1); end
        tests_run++; if (bus.in_ready !== 1'b1 || bus.mem_wr_enable !== 1'b1) begin tests_failed++; $display("FAIL fullpop_push_next: got ready=%b en=%b want 1 1", bus.in_ready, bus.mem_wr_enable); end
        advance();
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        advance();
    endtask

    task automatic test_stream();
        int tx = 0;
        int rx = 0;
        int gaps = 0;
        bit seen = 1'b0;
        for (int c = 0; c < 80 && rx < 40; c++) begin
            drive(tx < 40, W'(tx), 1'b1, 1'b0, 1'b0);
            if (seen && bus.out_valid !== 1'b1) gaps++;
            if (bus.out_valid === 1'b1) begin
                seen = 1'b1;
                tests_run++; if (bus.out_data !== W'(rx)) begin tests_failed++; $display("FAIL stream_data[%0d]: got %h want %h", rx, bus.out_data, W'(rx)); end
                rx++;
            end
            if (exp_push) tx++;
            advance();
        end
        tests_run++; if (rx != 40) begin tests_failed++; $display("FAIL stream_count: got %0d want 40", rx); end
        tests_run++; if (gaps != 0) begin tests_failed++; $display("FAIL stream_gaps: got %0d want 0", gaps); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, W'(8'h40 + i), 1'b0, 1'b0, 1'b0);
            advance();
        end
        drive(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
        tests_run++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_block: got ready=%b valid=%b want 0 0", bus.in_ready, bus.out_valid); end
        advance();
        drive(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        tests_run++; if (bus.level !== LW'(0) || bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_cleared: got level=%0d valid=%b want 0 0", bus.level, bus.out_valid); end
        advance();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_early_valid: got %b want 0", bus.out_valid); end
        advance();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tests_run++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3C) begin tests_failed++; $display("FAIL flush_new_word: got valid=%b data=%h want valid=1 data=3c", bus.out_valid, bus.out_data); end
        advance();
    endtask

    task automatic test_reset_mid();
        int pops = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, W'(8'h20 + i), 1'b0, 1'b0, 1'b0);
            advance();
        end
        drive(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1);
        tests_run++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.mem_wr_enable !== 1'b0) begin tests_failed++; $display("FAIL midrst_outputs: got ready=%b valid=%b en=%b want 0 0 0", bus.in_ready, bus.out_valid, bus.mem_wr_enable); end
        advance();
        drive(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        tests_run++; if (bus.level !== LW'(0) || bus.mem_rd_address !== 4'd0 || bus.overflow !== 1'b0 || bus.peak_level !== LW'(0)) begin tests_failed++; $display("FAIL midrst_state: got level=%0d addr=%0d ovf=%b peak=%0d want all 0", bus.level, bus.mem_rd_address, bus.overflow, bus.peak_level); end
        advance();
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            if (bus.out_valid === 1'b1) begin
                tests_run++; if (pops == 0 && bus.out_data !== 8'h5A) begin tests_failed++; $display("FAIL midrst_word: got %h want 5a", bus.out_data); end
                pops++;
            end
            advance();
        end
        tests_run++; if (pops != 1) begin tests_failed++; $display("FAIL midrst_pops: got %0d want 1", pops); end
    endtask

    task automatic test_random();
        logic v, r, f, rs;
        for (int i = 0; i < 600; i++) begin
            if (((i / 100) % 2) == 0) begin
                v = ($urandom_range(0, 9) < 8);
                r = ($urandom_range(0, 9) < 3);
            end else begin
                v = ($urandom_range(0, 9) < 3);
                r = ($urandom_range(0, 9) < 8);
            end
            f  = ($urandom_range(0, 39) == 0);
            rs = ($urandom_range(0, 119) == 0);
            drive(v, W'($urandom), r, f, rs);
            tests_run++; if (bus.in_ready !== exp_in_ready) begin tests_failed++; $display("FAIL rnd_in_ready @%0d: got %b want %b", i, bus.in_ready, exp_in_ready); end
            tests_run++; if (bus.out_valid !== exp_out_valid) begin tests_failed++; $display("FAIL rnd_out_valid @%0d: got %b want %b", i, bus.out_valid, exp_out_valid); end
            if (exp_out_valid) begin
                tests_run++; if (bus.out_data !== exp_out_data) begin tests_failed++; $display("FAIL rnd_out_data @%0d: got %h want %h", i, bus.out_data, exp_out_data); end
            end
            if (!rs) begin
                tests_run++; if (bus.level !== LW'(q.size())) begin tests_failed++; $display("FAIL rnd_level @%0d: got %0d want %0d", i, bus.level, q.size()); end
            end
            tests_run++; if (bus.mem_wr_enable !== exp_push) begin tests_failed++; $display("FAIL rnd_wr_en @%0d: got %b want %b", i, bus.mem_wr_enable, exp_push); end
            if (exp_push) begin
                tests_run++; if (bus.mem_wr_address !== 4'(wr_count % D) || bus.mem_wr_data !== bus.in_data) begin tests_failed++; $display("FAIL rnd_wr_port @%0d: got addr=%0d data=%h want addr=%0d data=%h", i, bus.mem_wr_address, bus.mem_wr_data, wr_count % D, bus.in_data); end
            end
            tests_run++; if (bus.overflow !== exp_ovf) begin tests_failed++; $display("FAIL rnd_overflow @%0d: got %b want %b", i, bus.overflow, exp_ovf); end
            tests_run++; if (bus.peak_level !== LW'(exp_peak)) begin tests_failed++; $display("FAIL rnd_peak @%0d: got %0d want %0d", i, bus.peak_level, exp_peak); end
            advance();
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        test_reset();
        test_first_word();
        test_full();
        test_full_pop();
        test_stream();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/uart_fifo_ctrl.md
UART_FIFO_CTRL -- requirements
Module: uart_fifo_ctrl

Interface
REQ-001 Parameter Width, default 8, SHALL set the data word width in bits.
REQ-002 Parameter Depth, default 16, SHALL set the number of RAM entries; it is a power of two and at least 2.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 flush  input  1  SHALL discard all stored words when high.
REQ-006 in_valid / in_ready / in_data  input / output / input  1 / 1 / Width  SHALL form the write-side valid-ready handshake.
REQ-007 out_valid / out_ready / out_data  output / input / output  1 / 1 / Width  SHALL form the read-side valid-ready handshake.
REQ-008 level  output  $clog2(Depth)+1  SHALL report the number of words written and not yet popped.
REQ-009 mem_wr_enable / mem_wr_address / mem_wr_data  output  1 / $clog2(Depth) / Width  SHALL drive the RAM write port.
REQ-010 mem_rd_address / mem_rd_data  output / input  $clog2(Depth) / Width  SHALL connect to the RAM read port, which has 1-cycle synchronous read latency.
REQ-011 overflow / peak_level  output  1 / $clog2(Depth)+1  SHALL provide the statistics described in Configuration.

Function
REQ-012 Push: in_valid && in_ready in a cycle with flush=0 SHALL write the word; a pop is the same rule using out_valid && out_ready.
REQ-013 in_ready SHALL be (level < Depth) && !flush, with no combinational dependence on out_ready.
REQ-014 mem_wr_enable SHALL equal the push condition, with mem_wr_address = wr_ptr and mem_wr_data = in_data, all combinational.
REQ-015 wr_ptr and rd_ptr SHALL be $clog2(Depth) bits wide and SHALL wrap from Depth-1 to 0.
REQ-016 wr_ptr SHALL increment on push; rd_ptr SHALL increment on pop.
REQ-017 mem_rd_address SHALL be rd_ptr+1 (mod Depth) in a pop cycle, otherwise rd_ptr.
REQ-018 out_data SHALL be mem_rd_data, passed through combinationally.
REQ-019 level SHALL increment on push only, decrement on pop only, and hold when push and pop occur together.
REQ-020 The visible count vcount SHALL increment one cycle after each push (registered push flag) and decrement on pop.
REQ-021 out_valid SHALL be (vcount != 0) && !flush.
REQ-022 A word pushed in cycle t SHALL first present on out_data with out_valid=1 in cycle t+2 when the controller was empty.
REQ-023 With out_ready held high and a steady push stream, the controller SHALL sustain one pop per cycle and deliver words in push order.
REQ-024 When full, a push attempt with a simultaneous pop SHALL NOT be accepted; in_ready SHALL rise in the next cycle.
REQ-025 Flush SHALL zero wr_ptr, rd_ptr, level, vcount and the push flag at the edge; push and pop SHALL be blocked in the flush cycle.
REQ-026 level SHALL never exceed Depth, and vcount SHALL never underflow.

Reset
REQ-027 On rst=1 at an edge, wr_ptr, rd_ptr, level, vcount, the push flag, overflow and peak_level SHALL clear to 0.
REQ-028 While rst is high: in_ready=0, out_valid=0, mem_wr_enable=0.
REQ-029 After reset, out_valid=0 and mem_rd_address=0; mem_rd_data is ignored until vcount is non-zero.
REQ-030 A reset mid-stream SHALL discard stored words; no pre-reset word SHALL appear after reset.

Configuration
REQ-031 Macro UART_FIFO_CTRL_STATS_EN, when defined, SHALL enable the statistics outputs:
- overflow: set sticky by a cycle with in_valid=1, in_ready=0, level=Depth.
- peak_level: holds the maximum level reached.
- Both cleared only by rst; flush SHALL NOT clear them.
REQ-032 Without UART_FIFO_CTRL_STATS_EN, overflow and peak_level SHALL still exist as ports tied to 0, and no statistics registers SHALL be built.

Verification (Width=8, Depth=16, behavioural RAM model attached)
REQ-033 Reset, then push 0xA5 in cycle 0 -> level=1 in cycle 1; out_valid=1 and out_data=0xA5 in cycle 2.
REQ-034 out_ready=0, push 0x00..0x0F -> level=16, in_ready=0; a 17th in_valid with 0xFF is not written; overflow=1 and peak_level=16 (with macro), both 0 (without macro).
REQ-035 out_ready=1, stream 40 words 0x00..0x27 -> all popped in order with no gaps after the first out_valid; pointers wrap twice.
REQ-036 Full, then in_valid=1 and out_ready=1 together -> pop of 0x00, push rejected, level=15; push accepted the following cycle.
REQ-037 5 words stored, flush for one cycle -> level=0 and out_valid=0 the next cycle; then push 0x3C -> out_data=0x3C with out_valid=1 two cycles later.
REQ-038 3 words stored, rst for one cycle mid-stream -> all outputs at reset values; a new push of 0x5A is the next and only word popped.
